xadc_temp_monitor: RTL



---
 rtl/xadc_temp_pkg.sv | 36 +++
 rtl/xadc_avg_buffer.sv | 81 ++++++++
 rtl/xadc_temp_monitor.sv | 135 +++++++++++++
 3 files changed

// File: rtl/xadc_temp_pkg.sv
// Shared constants and types for the XADC temperature monitor.
// Register map, code-to-degree conversion and FSM states.
package xadc_temp_pkg;

  localparam int REG_TEMP   = 0;
  localparam int REG_MIN    = 1;
  localparam int REG_MAX    = 2;
  localparam int REG_THRESH = 3;
  localparam int REG_HYST   = 4;
  localparam int REG_STATUS = 5;
  localparam int REG_CTRL   = 6;

  localparam logic [11:0] CODE_OFFSET = 12'd2226;
  localparam int          CONV_SHIFT  = 3;

  localparam logic [7:0] THRESH_RST = 8'd85;
  localparam logic [7:0] HYST_RST   = 8'd5;

  typedef enum logic {
    empty_e,
    run_e
  } state_t;

  // Codes below the offset are clamped to 0 degrees.
  function automatic logic [7:0] code_to_temp(
    input logic [11:0] avg
  );
    logic [11:0] diff;
    if (avg < CODE_OFFSET) begin
      return 8'd0;
    end
    diff = (avg - CODE_OFFSET) >> CONV_SHIFT;
    return diff[7:0];
  endfunction

endpackage

// File: rtl/xadc_avg_buffer.sv
// Power-of-two moving average over raw XADC codes.
// First sample primes every slot so the average starts settled.
module xadc_avg_buffer
  import xadc_temp_pkg::*;
#(
  parameter int AvgLog2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [11:0] sample_code,
  output logic        avg_valid,
  output logic [11:0] avg
);

  localparam int Depth = 1 << AvgLog2;
  localparam int SumW  = 12 + AvgLog2;

  state_t state_q;
  state_t state_d;
  logic   prime;
  logic   shift;

  logic [11:0]        mem_q [Depth];
  logic [AvgLog2-1:0] ptr_q;
  logic [SumW-1:0]    sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= empty_e;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      empty_e: if (sample_valid) state_d = run_e;
      run_e:   state_d = run_e;
      default: state_d = empty_e;
    endcase
  end

  always_comb begin
    prime = 1'b0;
    shift = 1'b0;
    unique case (state_q)
      empty_e: prime = sample_valid;
      run_e:   shift = sample_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      ptr_q     <= '0;
      sum_q     <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= sample_valid;
      if (prime) begin
        for (int i = 0; i < Depth; i++) begin
          mem_q[i] <= sample_code;
        end
        sum_q <= SumW'(sample_code) << AvgLog2;
      end else if (shift) begin
        mem_q[ptr_q] <= sample_code;
        sum_q <= sum_q + SumW'(sample_code)
               - SumW'(mem_q[ptr_q]);
        ptr_q <= ptr_q + AvgLog2'(1);
      end
    end
  end

  assign avg = sum_q[SumW-1 -: 12];

endmodule

// File: rtl/xadc_temp_monitor.sv
// XADC temperature monitor: averaging, conversion, min/max,
// hysteretic over-temperature alarm and 8-bit register bus.
module xadc_temp_monitor
  import xadc_temp_pkg::*;
#(
  parameter int BaseAddress   = 0,
  parameter int address_width = 16,
  parameter int data_width    = 8,
  parameter int AvgLog2       = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     sample_valid_i,
  input  logic [11:0]              sample_code_i,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  input  logic                     rd_wr_i,
  output logic [data_width-1:0]    data_o,
  output logic                     alarm_o
);

  logic        avg_valid;
  logic [11:0] avg;

  xadc_avg_buffer #(
    .AvgLog2(AvgLog2)
  ) u_avg (
    .clk         (clk_i),
    .rst         (reset_i),
    .sample_valid(sample_valid_i),
    .sample_code (sample_code_i),
    .avg_valid   (avg_valid),
    .avg         (avg)
  );

  logic [address_width-1:0] offs;
  logic [7:0] wdata;
  logic [7:0] temp_next;
  logic [7:0] lower;
  logic [7:0] rd_mux;
  logic [7:0] temp_q, min_q, max_q;
  logic [7:0] thresh_q, hyst_q;
  logic valid_q, loaded_q, upd_q;
  logic alarm_q, sticky_q;
  logic alarm_set, alarm_clr;
  logic thresh_wr, hyst_wr;
  logic status_wr, ctrl_wr;

  assign offs  = address_i - address_width'(BaseAddress);
  assign wdata = 8'(data_i);

  assign thresh_wr = rd_wr_i && offs == address_width'(REG_THRESH);
  assign hyst_wr   = rd_wr_i && offs == address_width'(REG_HYST);
  assign status_wr = rd_wr_i && offs == address_width'(REG_STATUS);
  assign ctrl_wr   = rd_wr_i && offs == address_width'(REG_CTRL);

  assign temp_next = code_to_temp(avg);
  assign lower     = (hyst_q > thresh_q) ? 8'd0 : thresh_q - hyst_q;
  assign alarm_set = upd_q && temp_q >= thresh_q;
  assign alarm_clr = upd_q && temp_q < lower;

  // A CTRL write coincident with an update reloads from the new TEMP.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      temp_q   <= '0;
      min_q    <= '0;
      max_q    <= '0;
      valid_q  <= 1'b0;
      loaded_q <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      upd_q <= avg_valid;
      if (avg_valid) begin
        temp_q   <= temp_next;
        valid_q  <= 1'b1;
        loaded_q <= 1'b1;
        if (!loaded_q || ctrl_wr) begin
          min_q <= temp_next;
          max_q <= temp_next;
        end else begin
          if (temp_next < min_q) min_q <= temp_next;
          if (temp_next > max_q) max_q <= temp_next;
        end
      end else if (ctrl_wr) begin
        min_q    <= '0;
        max_q    <= '0;
        loaded_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      thresh_q <= THRESH_RST;
      hyst_q   <= HYST_RST;
      alarm_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (thresh_wr) thresh_q <= wdata;
      if (hyst_wr)   hyst_q   <= wdata;
      if (alarm_set) begin
        alarm_q <= 1'b1;
      end else if (alarm_clr) begin
        alarm_q <= 1'b0;
      end
      sticky_q <= alarm_set
                | (sticky_q & ~(status_wr & wdata[2]));
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (offs == address_width'(REG_TEMP)):   rd_mux = temp_q;
      (offs == address_width'(REG_MIN)):    rd_mux = min_q;
      (offs == address_width'(REG_MAX)):    rd_mux = max_q;
      (offs == address_width'(REG_THRESH)): rd_mux = thresh_q;
      (offs == address_width'(REG_HYST)):   rd_mux = hyst_q;
      (offs == address_width'(REG_STATUS)):
        rd_mux = {5'd0, sticky_q, valid_q, alarm_q};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_o <= '0;
    end else if (!rd_wr_i) begin
      data_o <= data_width'(rd_mux);
    end
  end

  assign alarm_o = alarm_q;

endmodule
